i2c_cfg_arbiter: RTL and testbench
==================================

Name: i2c_cfg_arbiter

Overview:
- Shares one I2C byte-transaction engine (GO/WR/END/ACK handshake, 24-bit {slave, reg, data} word) between two requesters, e.g. sensor boot-config sequencer and runtime register read/write port.
- Round-robin grant, retry on NACK, END-wait timeout, one-cycle completion pulse per requester.
- Sits between the requesters and the engine in the camera config subsystem.

Parameters:
- MAX_RETRY, 3, extra attempts after a NACK before reporting error (0..15).
- TIMEOUT_CYC, 200000, iCLK cycles allowed in ISSUE+BUSY per attempt before abort.
- GAP_CYC, 4, idle iCLK cycles with eng_go low between attempts/transactions (>=1).

Ports:
- iCLK  in  1  clock.
- iRST_N  in  1  async reset, active-low.
- req  in  2  per-requester request level; bit i = requester i.
- wr0, wr1  in  1  1 = write, 0 = read, for requester 0/1.
- wdata0, wdata1  in  24  {slave_addr, reg_addr, data}, requester 0/1.
- gnt  out  2  one-hot current owner; 0 when idle.
- done  out  2  one-cycle completion pulse per requester.
- err  out  1  valid with done: 1 = NACK after retries, or timeout.
- tmo  out  1  valid with done: 1 = error cause was timeout.
- rdata  out  8  read byte, valid with done, held until next done.
- busy  out  1  high in any state except IDLE.
- eng_go  out  1  engine start level.
- eng_wr  out  1  engine write/read select.
- eng_wdata  out  24  word to engine.
- eng_end  in  1  engine idle/finished (high when idle, low while running).
- eng_ack  in  1  engine ack result; 0 = ACK (success), 1 = NACK.
- eng_rdata  in  8  engine read byte.

Behaviour:
- Reset: clock iCLK, reset iRST_N asynchronous active-low. Outputs, state, counters and the RR pointer all 0. State IDLE. Pointer 0 favours requester 0 first. Reset mid-transaction drops eng_go immediately; no done is issued.
- All eng_* inputs are sampled on posedge iCLK. The engine is clocked by the same iCLK.
- IDLE:
  - Single req bit set: grant that requester.
  - Both set: grant the one not granted last (RR pointer).
  - On grant: gnt set, eng_wdata/eng_wr latched from the winner, retry_cnt=0, timer=0, go to ISSUE.
  - Next grant is decided the cycle after GAP ends, never in the same cycle as done.
- ISSUE: eng_go=1. Wait for eng_end==0 (engine accepted), then go to BUSY.
- BUSY: eng_go held 1. Wait for eng_end==1, then go to CHECK.
- CHECK (1 cycle): eng_go=0.
  - eng_ack==0: success. Capture rdata from eng_rdata if read, pulse done[i], err=0, go to GAP.
  - eng_ack==1 and retry_cnt<MAX_RETRY: retry_cnt++, go to GAP, then re-enter ISSUE for the same owner with the same latched word. gnt stays set.
  - eng_ack==1 and retry_cnt==MAX_RETRY: pulse done[i], err=1, tmo=0, go to GAP.
- Timeout: timer counts every cycle in ISSUE/BUSY and resets per attempt. When timer==TIMEOUT_CYC-1: eng_go=0, done[i], err=1, tmo=1, go to GAP. Timeout is not retried.
- GAP: eng_go=0 for GAP_CYC cycles.
  - Completed transaction: gnt cleared on GAP entry, then IDLE.
  - Retry: back to ISSUE.
- RR pointer updates to the owner on grant.
- Requester rules:
  - req, wr, wdata must stay stable until done. Latched values are used, so later changes are ignored.
  - Dropping req before grant withdraws the request.
  - Dropping req after grant does not abort; done still pulses.
- done, err and tmo are zero outside the done cycle. rdata is unchanged on writes and on errors.
- eng_wdata/eng_wr stay stable from grant through CHECK.

Test Plan:
- Requester 0 writes 0x42_12_80; engine pulls END low 3 cycles after go, high 20 later with ACK=0. Required: gnt=01, eng_wdata=0x421280, eng_wr=1, done[0] exactly 1 cycle with err=0, then busy low after GAP_CYC.
- Both req raised same cycle from reset. Required: requester 0 served first, then requester 1. On a repeated simultaneous request: requester 0 again (pointer=1 after serving 1); gnt never both bits.
- Requester 1 reads 0x43_0A_00, engine returns ACK=0, rdata=0x76. Required: done[1], rdata=0x76, and it stays 0x76 through a subsequent write.
- Engine always returns NACK, MAX_RETRY=3. Required: exactly 4 eng_go assertions separated by >=GAP_CYC low cycles, then done with err=1, tmo=0.
- Engine never lowers END. Required: eng_go drops after TIMEOUT_CYC cycles, done with err=1, tmo=1, and no retry.
- iRST_N asserted during BUSY. Required: eng_go, gnt and busy go to 0 asynchronously, no done. After release, a pending req is granted fresh from ISSUE.

Source files
------------

// File: rtl/i2c_cfg_arbiter.sv
// Round-robin arbiter sharing one I2C byte engine between two requesters,
// with NACK retry, per-attempt timeout and an enforced idle gap between attempts.
//
// state | meaning
// IDLE  | no owner; pick a winner from req
// ISSUE | eng_go high, waiting for the engine to drop eng_end
// BUSY  | eng_go high, waiting for the engine to raise eng_end
// CHECK | eng_go low, judge eng_ack: done, retry or error
// GAP   | eng_go low for GAP_CYC cycles before retry or IDLE
module i2c_cfg_arbiter #(
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 200000,
    parameter int GAP_CYC     = 4
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [1:0]  req,
    input  logic        wr0,
    input  logic        wr1,
    input  logic [23:0] wdata0,
    input  logic [23:0] wdata1,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic        err,
    output logic        tmo,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        eng_go,
    output logic        eng_wr,
    output logic [23:0] eng_wdata,
    input  logic        eng_end,
    input  logic        eng_ack,
    input  logic [7:0]  eng_rdata
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYC - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_BUSY  = 3'd2,
        S_CHECK = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    last_q, last_d;
    logic          owner_q, owner_d;
    logic          wr_q, wr_d;
    logic [23:0]   wdata_q, wdata_d;
    logic [3:0]    retry_q, retry_d;
    logic          retry_pend_q, retry_pend_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          go_q, go_d;
    logic [1:0]    done_q, done_d;
    logic          err_q, err_d;
    logic          tmo_q, tmo_d;
    logic [7:0]    rdata_q, rdata_d;

    logic          win;
    logic [1:0]    owner_oh;
    logic          tmo_hit;

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_d       = last_q;
        owner_d      = owner_q;
        wr_d         = wr_q;
        wdata_d      = wdata_q;
        retry_d      = retry_q;
        retry_pend_d = retry_pend_q;
        timer_d      = timer_q;
        gap_d        = gap_q;
        go_d         = go_q;
        done_d       = 2'b00;
        err_d        = 1'b0;
        tmo_d        = 1'b0;
        rdata_d      = rdata_q;
        // last_q is the one-hot previous owner; 0 after reset so requester 0 wins a tie
        win          = (req == 2'b11) ? last_q[0] : req[1];
        owner_oh     = owner_q ? 2'b10 : 2'b01;
        tmo_hit      = ((state_q == S_ISSUE) || (state_q == S_BUSY)) && (timer_q == '0);

        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    gnt_d        = win ? 2'b10 : 2'b01;
                    last_d       = win ? 2'b10 : 2'b01;
                    owner_d      = win;
                    wr_d         = win ? wr1 : wr0;
                    wdata_d      = win ? wdata1 : wdata0;
                    retry_d      = '0;
                    retry_pend_d = 1'b0;
                    timer_d      = TMO_LOAD;
                    go_d         = 1'b1;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE, S_BUSY: begin
                if (tmo_hit) begin
                    go_d         = 1'b0;
                    done_d       = owner_oh;
                    err_d        = 1'b1;
                    tmo_d        = 1'b1;
                    gnt_d        = 2'b00;
                    retry_pend_d = 1'b0;
                    gap_d        = GAP_LOAD;
                    state_d      = S_GAP;
                end else begin
                    timer_d = timer_q - 1'b1;
                    if ((state_q == S_ISSUE) && !eng_end) begin
                        state_d = S_BUSY;
                    end else if ((state_q == S_BUSY) && eng_end) begin
                        go_d    = 1'b0;
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                gap_d   = GAP_LOAD;
                state_d = S_GAP;
                if (!eng_ack) begin
                    done_d = owner_oh;
                    gnt_d  = 2'b00;
                    if (!wr_q) begin
                        rdata_d = eng_rdata;
                    end
                end else if (retry_q < RETRY_MAX) begin
                    retry_d      = retry_q + 1'b1;
                    retry_pend_d = 1'b1;
                end else begin
                    done_d = owner_oh;
                    err_d  = 1'b1;
                    gnt_d  = 2'b00;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    if (retry_pend_q) begin
                        retry_pend_d = 1'b0;
                        timer_d      = TMO_LOAD;
                        go_d         = 1'b1;
                        state_d      = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                go_d    = 1'b0;
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q      <= S_IDLE;
            gnt_q        <= '0;
            last_q       <= '0;
            owner_q      <= 1'b0;
            wr_q         <= 1'b0;
            wdata_q      <= '0;
            retry_q      <= '0;
            retry_pend_q <= 1'b0;
            timer_q      <= '0;
            gap_q        <= '0;
            go_q         <= 1'b0;
            done_q       <= '0;
            err_q        <= 1'b0;
            tmo_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_q       <= last_d;
            owner_q      <= owner_d;
            wr_q         <= wr_d;
            wdata_q      <= wdata_d;
            retry_q      <= retry_d;
            retry_pend_q <= retry_pend_d;
            timer_q      <= timer_d;
            gap_q        <= gap_d;
            go_q         <= go_d;
            done_q       <= done_d;
            err_q        <= err_d;
            tmo_q        <= tmo_d;
            rdata_q      <= rdata_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign tmo       = tmo_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != S_IDLE);
    assign eng_go    = go_q;
    assign eng_wr    = wr_q;
    assign eng_wdata = wdata_q;

endmodule

// File: tb/tb_i2c_cfg_arbiter.sv
// Directed bench for i2c_cfg_arbiter with a behavioural engine whose reply
// (ack, nack, hang) is chosen per scenario.
module tb_i2c_cfg_arbiter;

    localparam int MAX_RETRY   = 3;
    localparam int TIMEOUT_CYC = 100;
    localparam int GAP_CYC     = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic        wr0 = 1'b0;
    logic        wr1 = 1'b0;
    logic [23:0] wdata0 = '0;
    logic [23:0] wdata1 = '0;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic        err;
    logic        tmo;
    logic [7:0]  rdata;
    logic        busy;
    logic        eng_go;
    logic        eng_wr;
    logic [23:0] eng_wdata;
    logic        eng_end = 1'b1;
    logic        eng_ack = 1'b0;
    logic [7:0]  eng_rdata = '0;

    int vectors = 0;
    int miscompares = 0;
    int eng_mode = 0;   // 0 = ack, 1 = always nack, 2 = never lowers END
    int go_age = 0;

    i2c_cfg_arbiter #(
        .MAX_RETRY(MAX_RETRY), .TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)
    ) dut (
        .iCLK(clk), .iRST_N(rst_n), .req(req), .wr0(wr0), .wr1(wr1),
        .wdata0(wdata0), .wdata1(wdata1), .gnt(gnt), .done(done), .err(err),
        .tmo(tmo), .rdata(rdata), .busy(busy), .eng_go(eng_go), .eng_wr(eng_wr),
        .eng_wdata(eng_wdata), .eng_end(eng_end), .eng_ack(eng_ack),
        .eng_rdata(eng_rdata)
    );

    always #5 clk = ~clk;

    // Engine: END low from the 3rd to the 22nd cycle of eng_go, driven on negedge
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            go_age  = 0;
            eng_end = 1'b1;
        end else begin
            if (eng_go) go_age = go_age + 1;
            else        go_age = 0;
            if (eng_mode == 2) eng_end = 1'b1;
            else               eng_end = !(go_age >= 3 && go_age < 23);
            eng_ack = (eng_mode == 1);
        end
    end

    task automatic run_until_done(input int limit, output logic ok, output logic [1:0] d,
                                  output logic e, output logic t, output logic [7:0] rd,
                                  output int rises, output int high, output int min_low,
                                  output int both);
        logic prev;
        int   low_run;
        ok = 1'b0; d = '0; e = 1'b0; t = 1'b0; rd = '0;
        rises = 0; high = 0; min_low = 1000000; both = 0; low_run = 0;
        prev = eng_go;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (gnt == 2'b11) both++;
            if (eng_go) begin
                if (!prev) begin
                    rises++;
                    if (rises > 1 && low_run < min_low) min_low = low_run;
                end
                high++;
                low_run = 0;
            end else begin
                low_run++;
            end
            prev = eng_go;
            if (done != 2'b00) begin
                ok = 1'b1; d = done; e = err; t = tmo; rd = rdata;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle wait: busy=%b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    task automatic wait_gnt(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (gnt !== 2'b00)  begin miscompares++; $display("FAIL reset gnt: got %b required 00", gnt); end
        vectors++;
        if (busy !== 1'b0)  begin miscompares++; $display("FAIL reset busy: got %b required 0", busy); end
        vectors++;
        if (eng_go !== 1'b0) begin miscompares++; $display("FAIL reset eng_go: got %b required 0", eng_go); end
        vectors++;
        if ({done, err, tmo} !== 4'b0000) begin
            miscompares++; $display("FAIL reset done/err/tmo: got %b required 0000", {done, err, tmo});
        end
        vectors++;
        if (rdata !== 8'h00) begin miscompares++; $display("FAIL reset rdata: got %h required 00", rdata); end
    endtask

    task automatic test_write();
        logic ok, e, t;
        logic [1:0] d;
        logic [7:0] rd;
        int rises, high, min_low, both;
        eng_mode = 0;
        wr0 = 1'b1; wdata0 = 24'h421280;
        req = 2'b01;
        wait_gnt(ok);
        vectors++;
        if (!ok || gnt !== 2'b01) begin miscompares++; $display("FAIL write gnt: got %b required 01", gnt); end
        vectors++;
        if (eng_wdata !== 24'h421280) begin
            miscompares++; $display("FAIL write eng_wdata: got %h required 421280", eng_wdata);
        end
        vectors++;
        if (eng_wr !== 1'b1) begin miscompares++; $display("FAIL write eng_wr: got %b required 1", eng_wr); end
        run_until_done(200, ok, d, e, t, rd, rises, high, min_low, both);
        req = 2'b00;
        vectors++;
        if (!ok || d !== 2'b01 || e !== 1'b0) begin
            miscompares++; $display("FAIL write done: ok=%b done=%b err=%b required done=01 err=0", ok, d, e);
        end
        vectors++;
        if (eng_wdata !== 24'h421280) begin
            miscompares++; $display("FAIL write eng_wdata hold: got %h required 421280", eng_wdata);
        end
        @(negedge clk);
        vectors++;
        if (done !== 2'b00) begin miscompares++; $display("FAIL write done width: got %b required 00", done); end
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL write gap busy: got %b required 1", busy); end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL write busy after gap: got %b required 0", busy); end
    endtask

    task automatic test_round_robin();
        logic ok, e, t;
        logic [1:0] d;
        logic [7:0] rd;
        int rises, high, min_low, both, both_total;
        do_reset();
        eng_mode = 0;
        both_total = 0;
        wr0 = 1'b1; wdata0 = 24'h420101;
        wr1 = 1'b1; wdata1 = 24'h430202;
        req = 2'b11;
        run_until_done(200, ok, d, e, t, rd, rises, high, min_low, both);
        both_total += both;
        req = 2'b10;
        vectors++;
        if (!ok || d !== 2'b01) begin miscompares++; $display("FAIL rr first: got done=%b required 01", d); end
        run_until_done(200, ok, d, e, t, rd, rises, high, min_low, both);
        both_total += both;
        req = 2'b00;
        vectors++;
        if (!ok || d !== 2'b10) begin miscompares++; $display("FAIL rr second: got done=%b required 10", d); end
        wait_idle("rr");
        req = 2'b11;
        wait_gnt(ok);
        vectors++;
        if (!ok || gnt !== 2'b01) begin miscompares++; $display("FAIL rr repeat gnt: got %b required 01", gnt); end
        run_until_done(200, ok, d, e, t, rd, rises, high, min_low, both);
        both_total += both;
        req = 2'b10;
        vectors++;
        if (!ok || d !== 2'b01) begin miscompares++; $display("FAIL rr third: got done=%b required 01", d); end
        run_until_done(200, ok, d, e, t, rd, rises, high, min_low, both);
        both_total += both;
        req = 2'b00;
        vectors++;
        if (!ok || d !== 2'b10) begin miscompares++; $display("FAIL rr fourth: got done=%b required 10", d); end
        vectors++;
        if (both_total != 0) begin miscompares++; $display("FAIL rr gnt both bits: got %0d cycles required 0", both_total); end
        wait_idle("rr end");
    endtask

    task automatic test_read();
        logic ok, e, t;
        logic [1:0] d;
        logic [7:0] rd;
        int rises, high, min_low, both;
        eng_mode = 0;
        wr1 = 1'b0; wdata1 = 24'h430A00; eng_rdata = 8'h76;
        req = 2'b10;
        run_until_done(200, ok, d, e, t, rd, rises, high, min_low, both);
        req = 2'b00;
        vectors++;
        if (!ok || d !== 2'b10 || e !== 1'b0) begin
            miscompares++; $display("FAIL read done: done=%b err=%b required 10/0", d, e);
        end
        vectors++;
        if (rd !== 8'h76) begin miscompares++; $display("FAIL read rdata: got %h required 76", rd); end
        wait_idle("read");
        eng_rdata = 8'h11;
        wr0 = 1'b1; wdata0 = 24'h42AA55;
        req = 2'b01;
        run_until_done(200, ok, d, e, t, rd, rises, high, min_low, both);
        req = 2'b00;
        vectors++;
        if (!ok || rdata !== 8'h76) begin
            miscompares++; $display("FAIL read hold over write: got %h required 76", rdata);
        end
        wait_idle("read end");
    endtask

    task automatic test_nack_retry();
        logic ok, e, t;
        logic [1:0] d;
        logic [7:0] rd;
        int rises, high, min_low, both;
        eng_mode = 1;
        eng_rdata = 8'h55;
        wr0 = 1'b0; wdata0 = 24'h420700;
        req = 2'b01;
        run_until_done(2000, ok, d, e, t, rd, rises, high, min_low, both);
        req = 2'b00;
        vectors++;
        if (!ok || d !== 2'b01 || e !== 1'b1 || t !== 1'b0) begin
            miscompares++; $display("FAIL nack done: ok=%b done=%b err=%b tmo=%b required 1/01/1/0", ok, d, e, t);
        end
        vectors++;
        if (rises != MAX_RETRY + 1) begin
            miscompares++; $display("FAIL nack attempts: got %0d required %0d", rises, MAX_RETRY + 1);
        end
        vectors++;
        if (min_low < GAP_CYC) begin
            miscompares++; $display("FAIL nack gap: got %0d low cycles required >= %0d", min_low, GAP_CYC);
        end
        vectors++;
        if (rd !== 8'h76) begin miscompares++; $display("FAIL nack rdata kept: got %h required 76", rd); end
        wait_idle("nack");
        eng_mode = 0;
    endtask

    task automatic test_timeout();
        logic ok, e, t;
        logic [1:0] d;
        logic [7:0] rd;
        int rises, high, min_low, both, extra;
        eng_mode = 2;
        wr0 = 1'b1; wdata0 = 24'h421111;
        req = 2'b01;
        run_until_done(1000, ok, d, e, t, rd, rises, high, min_low, both);
        req = 2'b00;
        vectors++;
        if (!ok || d !== 2'b01 || e !== 1'b1 || t !== 1'b1) begin
            miscompares++; $display("FAIL timeout done: ok=%b done=%b err=%b tmo=%b required 1/01/1/1", ok, d, e, t);
        end
        vectors++;
        if (high != TIMEOUT_CYC) begin
            miscompares++; $display("FAIL timeout go length: got %0d required %0d", high, TIMEOUT_CYC);
        end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (eng_go) extra++;
        end
        vectors++;
        if (extra != 0) begin miscompares++; $display("FAIL timeout retried: got %0d go cycles required 0", extra); end
        wait_idle("timeout");
        eng_mode = 0;
    endtask

    task automatic test_reset_mid();
        logic ok, e, t;
        logic [1:0] d;
        logic [7:0] rd;
        int rises, high, min_low, both, n, seen;
        eng_mode = 0;
        wr0 = 1'b1; wdata0 = 24'h42BEEF;
        req = 2'b01;
        n = 0;
        while (eng_end && n < 50) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (eng_end !== 1'b0) begin miscompares++; $display("FAIL rstmid busy reached: eng_end=%b required 0", eng_end); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({eng_go, gnt, busy} !== 4'b0000) begin
            miscompares++; $display("FAIL rstmid async clear: go/gnt/busy=%b required 0000", {eng_go, gnt, busy});
        end
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done != 2'b00) seen++;
        end
        rst_n = 1'b1;
        run_until_done(200, ok, d, e, t, rd, rises, high, min_low, both);
        req = 2'b00;
        vectors++;
        if (seen != 0) begin miscompares++; $display("FAIL rstmid done during reset: got %0d required 0", seen); end
        vectors++;
        if (!ok || d !== 2'b01 || e !== 1'b0 || rises != 1) begin
            miscompares++; $display("FAIL rstmid fresh grant: ok=%b done=%b err=%b rises=%0d required 1/01/0/1", ok, d, e, rises);
        end
        wait_idle("rstmid");
    endtask

    initial begin
        test_reset();
        test_write();
        test_round_robin();
        test_read();
        test_nack_retry();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
